cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter LINES, default 64, number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rd_en  input  1  memory-stage read request.
REQ-005 SHALL have port wr_en  input  1  memory-stage write request.
REQ-006 SHALL have port address  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port write_data  input  32  store data.
REQ-008 SHALL have port read_data  output  32  load data to the memory stage.
REQ-009 SHALL have port freeze  output  1  pipeline stall request.
REQ-010 SHALL have port sram_rd_en  output  1  read request to the downstream SRAM controller.
REQ-011 SHALL have port sram_wr_en  output  1  write request to the SRAM controller.
REQ-012 SHALL have port sram_address  output  32  word-aligned address to the SRAM controller.
REQ-013 SHALL have port sram_write_data  output  32  store data to the SRAM controller.
REQ-014 SHALL have port sram_read_data  input  32  data returned by the SRAM controller.
REQ-015 SHALL have port sram_ready  input  1  one-cycle completion pulse from the SRAM controller.

Function
REQ-016 SHALL decode the address as index = address[IW+1:2] (IW = log2(LINES)) and tag = address[18:IW+2]; bits [31:19] SHALL be ignored.
REQ-017 SHALL hold per line one valid bit, one tag and one 32-bit data word.
REQ-018 SHALL implement exactly three states: IDLE, READ_MISS and WRITE_THRU.
REQ-019 Hit SHALL mean valid[index] = 1 and stored tag = request tag, evaluated combinationally in IDLE.
REQ-020 In IDLE, a read hit SHALL drive read_data = line data combinationally, with freeze = 0 and no SRAM request.
REQ-021 In IDLE, a read miss SHALL assert freeze combinationally, latch address, and move to READ_MISS on the next edge.
REQ-022 In READ_MISS, the block SHALL hold sram_rd_en = 1, hold sram_address = {latched address[31:2], 2'b00} and keep freeze = 1 until sram_ready = 1.
REQ-023 On the sram_ready cycle in READ_MISS, the block SHALL drive read_data = sram_read_data and freeze = 0 combinationally.
REQ-024 On that same edge, the block SHALL write data, tag and valid = 1 into the line and return to IDLE.
REQ-025 Writes SHALL be write-through and no-write-allocate: in IDLE, wr_en SHALL assert freeze, latch address and write_data, and move to WRITE_THRU.
REQ-026 In WRITE_THRU, the block SHALL hold sram_wr_en = 1 with the latched address and data until sram_ready = 1.
REQ-027 On the sram_ready cycle in WRITE_THRU, freeze SHALL drop to 0 and the state SHALL return to IDLE.
REQ-028 On the sram_ready edge in WRITE_THRU, a line whose tag matches SHALL have its data updated; a non-matching line SHALL be left unchanged.
REQ-029 When rd_en and wr_en are both 1, the write SHALL take priority and the read SHALL be ignored.
REQ-030 sram_rd_en and sram_wr_en SHALL never be 1 simultaneously, and both SHALL be 0 in IDLE.
REQ-031 A request whose address changes while the block is in READ_MISS or WRITE_THRU SHALL have no effect, because only latched values are used.
REQ-032 sram_ready received in IDLE SHALL be ignored.
REQ-033 Requests SHALL be accepted back-to-back: a request present in IDLE on the cycle after a return SHALL be evaluated normally.
REQ-034 Miss latency SHALL be 1 + N cycles, where N is the cycles until sram_ready; hit latency SHALL be 0 cycles.

Reset
REQ-035 While rst = 0, the state SHALL be IDLE, all valid bits SHALL be 0, and freeze, sram_rd_en, sram_wr_en SHALL be 0.
REQ-036 While rst = 0, read_data, sram_address and sram_write_data SHALL be 0; tag and data arrays need not be cleared.
REQ-037 Reset asserted mid-miss or mid-write SHALL abort the transaction immediately (asynchronously) and leave the target line invalid or unchanged.

Verification
REQ-038 After reset, read 0x100, SRAM returns 0xDEADBEEF after 5 cycles -> freeze high 6 cycles, read_data = 0xDEADBEEF on the ready cycle; line valid.
REQ-039 Repeat read 0x100 -> read_data = 0xDEADBEEF the same cycle, freeze = 0, sram_rd_en never asserted.
REQ-040 Write 0x12345678 to 0x100 -> sram_wr_en held until sram_ready; then read 0x100 hits with 0x12345678.
REQ-041 Read 0x500 (with LINES = 64, same index as 0x100, different tag) -> miss; afterwards 0x100 misses again.
REQ-042 Write 0x2000 to a never-read address, then read it -> the read misses (no allocate).
REQ-043 Assert rd_en and wr_en together, then pull rst low mid-WRITE_THRU -> only sram_wr_en is seen; all outputs reach 0 at once; IDLE after release.

Source files
------------

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through, no-write-allocate data cache controller
module cache_controller #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        freeze,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic        sram_ready
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 17 - IW;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU} state_t;

    state_t            r_state;
    logic [LINES-1:0]  r_valid;
    logic [TW-1:0]     r_tag  [LINES];
    logic [31:0]       r_data [LINES];
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;

    logic [IW-1:0] w_req_idx;
    logic [TW-1:0] w_req_tag;
    logic [IW-1:0] w_lat_idx;
    logic [TW-1:0] w_lat_tag;
    logic          w_hit;
    logic          w_lat_match;
    logic          w_unused_bits;

    assign w_req_idx     = address[IW+1:2];
    assign w_req_tag     = address[18:IW+2];
    assign w_lat_idx     = r_addr[IW+1:2];
    assign w_lat_tag     = r_addr[18:IW+2];
    assign w_hit         = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_lat_match   = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);
    assign w_unused_bits = ^{address[31:19], address[1:0], r_addr[1:0]};

    // Only latched address/data are used once a transaction leaves IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wr_en) begin
                        r_addr  <= address;
                        r_wdata <= write_data;
                        r_state <= WRITE_THRU;
                    end else if (rd_en && !w_hit) begin
                        r_addr  <= address;
                        r_state <= READ_MISS;
                    end
                end
                READ_MISS: begin
                    if (sram_ready) begin
                        r_valid[w_lat_idx] <= 1'b1;
                        r_state            <= IDLE;
                    end
                end
                WRITE_THRU: begin
                    if (sram_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity is owned by r_valid.
    always_ff @(posedge clk) begin
        if (rst && r_state == READ_MISS && sram_ready) begin
            r_tag[w_lat_idx]  <= w_lat_tag;
            r_data[w_lat_idx] <= sram_read_data;
        end else if (rst && r_state == WRITE_THRU && sram_ready && w_lat_match) begin
            r_data[w_lat_idx] <= r_wdata;
        end
    end

    assign sram_rd_en      = (r_state == READ_MISS);
    assign sram_wr_en      = (r_state == WRITE_THRU);
    assign sram_address    = {r_addr[31:2], 2'b00};
    assign sram_write_data = r_wdata;

    always_comb begin
        read_data = '0;
        freeze    = 1'b0;
        case (r_state)
            IDLE: begin
                freeze = rst && (wr_en || (rd_en && !w_hit));
                if (rd_en && !wr_en && w_hit) read_data = r_data[w_req_idx];
            end
            READ_MISS: begin
                freeze = !sram_ready;
                if (sram_ready) read_data = sram_read_data;
            end
            WRITE_THRU: freeze = !sram_ready;
            default: freeze = 1'b0;
        endcase
    end
endmodule
